regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//   Debug-side reader for the CPU register file. On a start pulse it walks the
//   register file's debug read port (dbg_reg -> dbg_content) over a range of
//   register numbers and streams each 32-bit value as 4 bytes, MSB first, on a
//   valid/ready byte interface toward the debug UART/display path.
//   It sits beside the register file and only reads it; it never writes it.
// PARAMETERS
//   NUM_REGS  32  number of architectural registers; addresses wrap modulo NUM_REGS
//   ADDR_W    5   width of register number; NUM_REGS == 2**ADDR_W
//   DATA_W    32  register width; must be 32 (4 bytes per register)
//   SETTLE    1   cycles dbg_reg is held before dbg_content is sampled (>=1)
// PORTS
//   clk          in   1       clock
//   rst          in   1       reset, asynchronous, active-low
//   start        in   1       1-cycle request to begin a dump (ignored while busy)
//   abort        in   1       cancel dump in progress
//   first_reg    in   ADDR_W  first register of range, latched on accepted start
//   last_reg     in   ADDR_W  last register of range, latched on accepted start
//   dbg_reg      out  ADDR_W  register number driven to register-file debug port
//   dbg_content  in   DATA_W  combinational read data from register-file debug port
//   byte_out     out  8       current output byte
//   byte_valid   out  1       byte_out holds a valid byte
//   byte_ready   in   1       sink accepts byte when byte_valid & byte_ready at clk edge
//   busy         out  1       high from accepted start until done or abort
//   done         out  1       1-cycle pulse after last byte of the range is accepted
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; dbg_reg=0, byte_out=0, byte_valid=0, busy=0,
//     done=0; latched range, settle counter and byte index cleared.
//   FSM: IDLE -> ADDR -> SEND -> (NEXT -> ADDR | DONE) -> IDLE.
//   IDLE: start=1 & abort=0 -> latch first/last, dbg_reg<=first, busy<=1, ADDR.
//     start=1 & abort=1 in the same cycle: abort wins, stay IDLE.
//   ADDR: hold dbg_reg for SETTLE cycles; on the last one, capture dbg_content into a
//     shift register, byte_out<=bits[31:24], byte_valid<=1, byte index<=0, go SEND.
//     With SETTLE=1 the first byte_valid rises 2 clk edges after the start edge.
//   SEND: byte_out and byte_valid are held stable while byte_valid & !byte_ready.
//     On a transfer: if index<3, present the next byte (23:16, 15:8, 7:0) the
//     following cycle with no bubble; if index==3, byte_valid<=0, go NEXT.
//   NEXT: if dbg_reg==latched last -> DONE; else dbg_reg<=(dbg_reg+1) mod NUM_REGS, ADDR.
//   DONE: done=1 for exactly one cycle, busy<=0, IDLE; busy is low in the cycle
//     after the done pulse.
//   Range: count=((last-first) mod NUM_REGS)+1; first>last wraps through NUM_REGS-1
//     to 0; first==last dumps one register. Total bytes = 4*count.
//   Register contents are sampled once per register; a register-file write after
//     capture does not change bytes already being sent.
//   start while busy: ignored, no effect on range or state.
//   abort while busy (any state): next edge -> IDLE, byte_valid<=0, busy<=0, no done
//     pulse; the only case where byte_valid falls without a transfer.
//   Async reset mid-dump: outputs return to reset values immediately; no done pulse.
// TESTING
//   1. Hold rst=0 for 3 cycles, start=1 -> all outputs 0, dbg_reg=0, no activity.
//   2. Model dbg_content={24'hC0FFEE,3'b0,dbg_reg}; first=last=5, ready=1 ->
//      bytes C0,FF,EE,05; done one cycle after the last byte; busy falls next.
//   3. first=0,last=31, ready=1, SETTLE=1 -> 128 bytes in register order 0..31,
//      one done pulse; check per-register gaps of exactly NEXT+ADDR cycles.
//   4. Same as 3 with random byte_ready -> byte_out/byte_valid stable during stall,
//      identical byte sequence, no byte dropped or duplicated.
//   5. first=30,last=1 -> registers 30,31,0,1 (16 bytes); then first=7,last=7 after done.
//   6. abort during SEND of reg 3 -> byte_valid low next cycle, busy=0, no done;
//      start during busy ignored; rst=0 mid-dump -> immediate reset values.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Streams a range of register-file entries out as bytes, MSB first, over a
// valid/ready byte interface. Reads the register file through its debug port only.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int SETTLE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] dbg_reg,
    input  logic [DATA_W-1:0] dbg_content,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              done
);

    localparam int                SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] REG_MAX     = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, SEND, NEXT, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] last_q;
    logic [SW-1:0]     settle_cnt;
    logic [23:0]       shift;
    logic [1:0]        byte_idx;

    // The top byte goes straight to byte_out at capture; only the remaining
    // three bytes need to be kept in the shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_q     <= '0;
            settle_cnt <= '0;
            shift      <= '0;
            byte_idx   <= '0;
            dbg_reg    <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort && state != IDLE) begin
            state      <= IDLE;
            settle_cnt <= '0;
            byte_idx   <= '0;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        last_q     <= last_reg;
                        dbg_reg    <= first_reg;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        shift      <= dbg_content[23:0];
                        byte_out   <= dbg_content[31:24];
                        byte_valid <= 1'b1;
                        byte_idx   <= '0;
                        settle_cnt <= '0;
                        state      <= SEND;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (byte_valid && byte_ready) begin
                        if (byte_idx == 2'd3) begin
                            byte_valid <= 1'b0;
                            state      <= NEXT;
                        end else begin
                            byte_out <= shift[23:16];
                            shift    <= {shift[15:0], 8'h00};
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (dbg_reg == last_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        dbg_reg <= (dbg_reg == REG_MAX) ? '0 : dbg_reg + 1'b1;
                        state   <= ADDR;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a register-file array model feeds
// the debug port and each dump is checked against a queue of expected bytes.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  dbg_reg;
    logic [31:0] dbg_content;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    int          tests = 0;
    int          fails = 0;

    assign dbg_content = regs[dbg_reg];

    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_reg(first_reg), .last_reg(last_reg),
        .dbg_reg(dbg_reg), .dbg_content(dbg_content),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dbg_reg"}, dbg_reg, 0);
        check({tag, "_byte_out"}, byte_out, 0);
        check({tag, "_byte_valid"}, byte_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 32; i++) regs[i] = {24'hC0FFEE, 3'b000, 5'(i)};
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) regs[i] = $urandom();
    endtask

    // Runs one complete dump and checks every byte, stall stability, the
    // inter-register gap, the done pulse and the fall of busy.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int ready_pct,
                            input bit poke_start, input bit rewrite);
        logic [7:0] exp_q[$];
        logic [7:0] prev_byte;
        int         count, cyc, last_reg_cyc, done_cyc, done_cnt, xfers;
        bit         prev_stall, prev_valid, finished, ready;
        count = ((int'(l) - int'(f) + 32) % 32) + 1;
        for (int i = 0; i < count; i++) begin
            for (int b = 3; b >= 0; b--) exp_q.push_back(regs[(int'(f) + i) % 32][8*b +: 8]);
        end
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_dbg_reg", dbg_reg, f);
        cyc = 0; last_reg_cyc = -2; done_cyc = -1; done_cnt = 0; xfers = 0;
        prev_stall = 0; prev_valid = 0; finished = 0; prev_byte = 0;
        while (!finished && cyc < 4000) begin
            if (prev_stall) begin
                check("stall_valid", byte_valid, 1);
                check("stall_byte", byte_out, prev_byte);
            end
            if (byte_valid && !prev_valid) check("reg_gap", cyc - last_reg_cyc, 3);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                check("done_timing", cyc - last_reg_cyc, 2);
                check("done_busy", busy, 1);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("busy_fall", busy, 0);
                check("done_width", done, 0);
                finished = 1;
            end
            if (poke_start && cyc == 5) begin
                first_reg = f + 5'd3;
                last_reg  = f;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            ready      = ($urandom_range(99) < ready_pct);
            byte_ready = ready;
            if (byte_valid && ready) begin
                if (exp_q.size() == 0) check("byte_count", xfers + 1, count * 4);
                else check("byte_data", byte_out, exp_q.pop_front());
                xfers++;
                if (xfers % 4 == 0) last_reg_cyc = cyc;
                if (rewrite) regs[dbg_reg] = $urandom();
            end
            prev_stall = byte_valid && !ready;
            prev_byte  = byte_out;
            prev_valid = byte_valid;
            @(negedge clk);
            cyc++;
        end
        start      = 1'b0;
        byte_ready = 1'b0;
        check("dump_finished", finished, 1);
        check("done_count", done_cnt, 1);
        check("bytes_left", exp_q.size(), 0);
        check("bytes_sent", xfers, count * 4);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  w;
        bit  seen;
        rst = 1'b0; start = 1'b1; abort = 1'b0; byte_ready = 1'b0;
        first_reg = 5'd3; last_reg = 5'd4;
        fill_pattern();

        // Reset held low with start asserted: nothing may move.
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("reset_hold");
        end
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // Single register: C0 FF EE 05.
        run_dump(5'd5, 5'd5, 100, 0, 0);
        // Full range, always ready.
        run_dump(5'd0, 5'd31, 100, 0, 0);
        // Full range with stalls and register-file writes after capture.
        run_dump(5'd0, 5'd31, 60, 0, 1);

        // Wrapping range with a start pulse while busy, then a single register.
        fill_random();
        run_dump(5'd30, 5'd1, 70, 1, 0);
        run_dump(5'd7, 5'd7, 100, 0, 0);

        // Abort while sending register 3.
        fill_random();
        first_reg = 5'd0; last_reg = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(dbg_reg == 5'd3 && byte_valid) && w < 500) begin
            byte_ready = 1'($urandom_range(1));
            @(negedge clk);
            w++;
        end
        check("abort_reached_reg3", (w < 500), 1);
        abort = 1'b1; byte_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; byte_ready = 1'b0;
        check("abort_valid", byte_valid, 0);
        check("abort_busy", busy, 0);
        seen = 0;
        repeat (6) begin
            seen |= done | busy | byte_valid;
            @(negedge clk);
        end
        check("abort_quiet", seen, 0);

        // Start and abort together while idle: abort wins.
        start = 1'b1; abort = 1'b1; first_reg = 5'd2; last_reg = 5'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_valid", byte_valid, 0);

        // Asynchronous reset in the middle of a dump.
        first_reg = 5'd0; last_reg = 5'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0; byte_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        #2 rst = 1'b0;
        #1 check_idle_outputs("async_reset");
        @(negedge clk);
        rst = 1'b1; byte_ready = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen |= done | busy;
        end
        check("post_reset_quiet", seen, 0);

        // Normal operation resumes after reset.
        run_dump(5'd2, 5'd4, 50, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
